// File: rtl/multiport_bram_pkg.sv
// multiport_bram_pkg: shared types and constants for the multi-read-port RAM.
// Holds the controller state encoding and the legal read-latency settings.
package multiport_bram_pkg;

   // Controller states: CLEAR sweeps zeros through the array, IDLE serves users.
   typedef enum logic {
      CLEAR = 1'b0,
      IDLE  = 1'b1
   } state_e;

   // Legal read latencies (cycles from request to o_valid).
   localparam int READ_LATENCY_ONE = 1;
   localparam int READ_LATENCY_TWO = 2;

   // True when a latency setting is one the read pipeline can build.
   function automatic bit read_latency_legal(input int lat);
      return (lat == READ_LATENCY_ONE) || (lat == READ_LATENCY_TWO);
   endfunction

endpackage

// File: rtl/bram_read_port.sv
// bram_read_port: one read lane of multiport_bram.
// Registers the raw array word, zeroes out-of-range reads, applies the
// same-cycle write collision policy and generates the valid strobe.
// Define MULTIPORT_BRAM_BYPASS_EN for write-first forwarding on collisions;
// otherwise the lane returns the previously stored word (read-first).
module bram_read_port
   import multiport_bram_pkg::*;
#(
   parameter int ADDR_WIDTH   = 6,
   parameter int RAM_WIDTH    = 8,
   parameter int RAM_DEPTH    = 21,
   parameter int READ_LATENCY = 1
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_req,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   input  logic [RAM_WIDTH-1:0]  i_mem_word,
   input  logic                  i_wr_hit,
   input  logic [RAM_WIDTH-1:0]  i_wr_data,
   output logic [RAM_WIDTH-1:0]  o_data,
   output logic                  o_valid,
   output logic                  o_oob
);

   localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(RAM_DEPTH);

   logic                 in_range;
   logic [RAM_WIDTH-1:0] word_sel;
   logic                 s1_valid_q, s1_valid_d;
   logic [RAM_WIDTH-1:0] s1_data_q, s1_data_d;

   assign in_range = ({1'b0, i_addr} < DEPTH_W);
   assign o_oob    = i_req & ~in_range;

`ifndef MULTIPORT_BRAM_BYPASS_EN
   // Collision inputs only matter when forwarding is built in.
   logic unused_fwd;
   assign unused_fwd = ^{i_wr_hit, i_wr_data};
`endif

   // First stage: pick the word (forwarded or stored), zero it when out of range.
   always_comb begin
      word_sel = i_mem_word;
`ifdef MULTIPORT_BRAM_BYPASS_EN
      if (i_wr_hit) begin
         word_sel = i_wr_data;
      end
`endif
      s1_valid_d = i_req;
      s1_data_d  = s1_data_q;
      if (i_req) begin
         s1_data_d = in_range ? word_sel : '0;
      end
   end

   // First stage registers; reset flushes any in-flight read.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         s1_valid_q <= 1'b0;
         s1_data_q  <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_data_q  <= s1_data_d;
      end
   end

   if (READ_LATENCY == READ_LATENCY_TWO) begin : g_lat2
      logic                 out_valid_q, out_valid_d;
      logic [RAM_WIDTH-1:0] out_data_q, out_data_d;

      // Second stage: delay the strobe, hold data until the next valid word.
      always_comb begin
         out_valid_d = s1_valid_q;
         out_data_d  = s1_valid_q ? s1_data_q : out_data_q;
      end

      // Second stage registers, flushed by reset like the first stage.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
         end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
         end
      end

      assign o_valid = out_valid_q;
      assign o_data  = out_data_q;
   end else begin : g_lat1
      assign o_valid = s1_valid_q;
      assign o_data  = s1_data_q;
   end

endmodule

// File: rtl/multiport_bram.sv
// multiport_bram: single-write, RAM_PORTS-read memory with a zeroing sweep.
// After reset (and on i_clr) the controller spends RAM_DEPTH cycles writing
// zeros; during that time user traffic is dropped and o_busy is high.
// Out-of-range accesses raise the sticky o_oob flag.
// Define MULTIPORT_BRAM_BYPASS_EN for write-first read/write collisions.
module multiport_bram
   import multiport_bram_pkg::*;
#(
   parameter int ADDR_WIDTH   = 6,
   parameter int RAM_WIDTH    = 8,
   parameter int RAM_DEPTH    = 21,
   parameter int RAM_PORTS    = 9,
   parameter int READ_LATENCY = 1
) (
   input  logic                            i_clk,
   input  logic                            i_rst_n,
   input  logic                            i_clr,
   input  logic                            i_wr_en,
   input  logic [ADDR_WIDTH-1:0]           i_w_addrs,
   input  logic [RAM_WIDTH-1:0]            i_data,
   input  logic [RAM_PORTS-1:0]            i_rd_en,
   input  logic [ADDR_WIDTH*RAM_PORTS-1:0] i_r_addrs,
   output logic [RAM_WIDTH*RAM_PORTS-1:0]  o_data,
   output logic [RAM_PORTS-1:0]            o_valid,
   output logic                            o_busy,
   output logic                            o_oob
);

   localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH + 1)'(RAM_DEPTH);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);
   localparam int                    IDX_W     = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

   if (!read_latency_legal(READ_LATENCY)) begin : g_bad_latency
      $error("multiport_bram: READ_LATENCY must be 1 or 2");
   end

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
   logic                  oob_q, oob_d;

   logic [RAM_WIDTH-1:0]  mem_q [RAM_DEPTH];
   logic                  mem_we;
   logic [IDX_W-1:0]      mem_waddr;
   logic [RAM_WIDTH-1:0]  mem_wdata;

   logic                  idle;
   logic                  w_in_range;
   logic                  wr_accept;
   logic                  wr_oob;
   logic [RAM_PORTS-1:0]  port_oob;

   assign idle       = (state_q == IDLE);
   assign w_in_range = ({1'b0, i_w_addrs} < DEPTH_W);
   assign wr_accept  = idle & i_wr_en & w_in_range;
   assign wr_oob     = idle & i_wr_en & ~w_in_range;
   assign o_busy     = (state_q == CLEAR);
   assign o_oob      = oob_q;

   // Next state, sweep counter, sticky flag and the single array write port.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      oob_d     = oob_q | wr_oob | (|port_oob);
      mem_we    = 1'b0;
      mem_waddr = i_w_addrs[IDX_W-1:0];
      mem_wdata = i_data;
      case (state_q)
         CLEAR: begin
            mem_we    = 1'b1;
            mem_waddr = cnt_q[IDX_W-1:0];
            mem_wdata = '0;
            if (cnt_q == LAST_ADDR) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         IDLE: begin
            mem_we = wr_accept;
            if (i_clr) begin
               state_d = CLEAR;
               cnt_d   = '0;
               oob_d   = 1'b0;
            end
         end
         default: begin
            state_d = CLEAR;
            cnt_d   = '0;
         end
      endcase
   end

   // Controller registers; reset lands in CLEAR so contents get zeroed.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= CLEAR;
         cnt_q   <= '0;
         oob_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         oob_q   <= oob_d;
      end
   end

   // Storage array; contents are not reset, only swept by CLEAR.
   always_ff @(posedge i_clk) begin
      if (mem_we) begin
         mem_q[mem_waddr] <= mem_wdata;
      end
   end

   for (genvar gi = 0; gi < RAM_PORTS; gi++) begin : g_port
      logic [ADDR_WIDTH-1:0] r_addr;
      logic [RAM_WIDTH-1:0]  rd_word;
      logic                  wr_hit;

      assign r_addr  = i_r_addrs[ADDR_WIDTH*gi +: ADDR_WIDTH];
      assign rd_word = mem_q[r_addr[IDX_W-1:0]];
      assign wr_hit  = wr_accept && (i_w_addrs == r_addr);

      bram_read_port #(
         .ADDR_WIDTH  (ADDR_WIDTH),
         .RAM_WIDTH   (RAM_WIDTH),
         .RAM_DEPTH   (RAM_DEPTH),
         .READ_LATENCY(READ_LATENCY)
      ) u_port (
         .i_clk     (i_clk),
         .i_rst_n   (i_rst_n),
         .i_req     (i_rd_en[gi] & idle),
         .i_addr    (r_addr),
         .i_mem_word(rd_word),
         .i_wr_hit  (wr_hit),
         .i_wr_data (i_data),
         .o_data    (o_data[RAM_WIDTH*gi +: RAM_WIDTH]),
         .o_valid   (o_valid[gi]),
         .o_oob     (port_oob[gi])
      );
   end

endmodule

// File: tb/tb_multiport_bram.sv
// tb_multiport_bram: directed checks for multiport_bram.
// A latency-1 and a latency-2 instance share all stimulus.
module tb_multiport_bram;

   localparam int AW    = 6;
   localparam int RW    = 8;
   localparam int DEPTH = 21;
   localparam int NP    = 9;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            clr;
   logic            wr_en;
   logic [AW-1:0]   w_addr;
   logic [RW-1:0]   w_data;
   logic [NP-1:0]   rd_en;
   logic [AW*NP-1:0] r_addrs;
   logic [RW*NP-1:0] o_data, o_data2;
   logic [NP-1:0]   o_valid, o_valid2;
   logic            o_busy, o_busy2, o_oob, o_oob2;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   multiport_bram #(.ADDR_WIDTH(AW), .RAM_WIDTH(RW), .RAM_DEPTH(DEPTH),
                    .RAM_PORTS(NP), .READ_LATENCY(1)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .i_wr_en(wr_en),
      .i_w_addrs(w_addr), .i_data(w_data), .i_rd_en(rd_en), .i_r_addrs(r_addrs),
      .o_data(o_data), .o_valid(o_valid), .o_busy(o_busy), .o_oob(o_oob));

   multiport_bram #(.ADDR_WIDTH(AW), .RAM_WIDTH(RW), .RAM_DEPTH(DEPTH),
                    .RAM_PORTS(NP), .READ_LATENCY(2)) dut2 (
      .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .i_wr_en(wr_en),
      .i_w_addrs(w_addr), .i_data(w_data), .i_rd_en(rd_en), .i_r_addrs(r_addrs),
      .o_data(o_data2), .o_valid(o_valid2), .o_busy(o_busy2), .o_oob(o_oob2));

   typedef struct {
      logic        wr_en;
      logic [5:0]  w_addr;
      logic [7:0]  w_data;
      logic [8:0]  rd_en;
      logic [5:0]  r_base;
      logic [5:0]  r_step;
      logic [8:0]  exp_valid;
      logic [71:0] exp_data;
      logic        exp_oob;
   } vec_t;

   vec_t vecs [9];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      clr   = 1'b0;
      wr_en = 1'b0;
      rd_en = '0;
   endtask

   // Port k reads base + k*step (6-bit wrap).
   task automatic set_reads(input logic [8:0] mask, input logic [5:0] base, input logic [5:0] step);
      rd_en = mask;
      for (int k = 0; k < NP; k++) r_addrs[AW*k +: AW] = base + AW'(k) * step;
   endtask

   task automatic read_all_zero(input string tag);
      logic [8:0] m;
      for (int b = 0; b < DEPTH; b += NP) begin
         m = '0;
         for (int k = 0; k < NP; k++) if (b + k < DEPTH) m[k] = 1'b1;
         set_reads(m, 6'(b), 6'd1);
         cycle();
         quiet();
         check($sformatf("%s_valid_b%0d", tag, b), o_valid, m);
         check($sformatf("%s_data_b%0d", tag, b), o_data, 0);
      end
   endtask

   int   n;
   logic seen;

   initial begin
      rst_n = 1'b0; clr = 1'b0; wr_en = 1'b0; w_addr = '0; w_data = '0;
      rd_en = '0; r_addrs = '0;

      //          wr    waddr  wdata  rd_en   base   step   exp_valid exp_data                                                              oob
      vecs[0] = '{1'b1, 6'd3,  8'hA5, 9'h000, 6'd0,  6'd0,  9'h000, 72'h0,                                                                1'b0};
      vecs[1] = '{1'b0, 6'd0,  8'h00, 9'h1FF, 6'd3,  6'd0,  9'h1FF, {9{8'hA5}},                                                           1'b0};
      vecs[2] = '{1'b1, 6'd5,  8'h11, 9'h000, 6'd0,  6'd0,  9'h000, {9{8'hA5}},                                                           1'b0};
      vecs[3] = '{1'b1, 6'd20, 8'h5A, 9'h003, 6'd5,  6'd0,  9'h003, {{7{8'hA5}}, 8'h11, 8'h11},                                           1'b0};
      vecs[4] = '{1'b1, 6'd0,  8'hC3, 9'h100, 6'd20, 6'd0,  9'h100, {8'h5A, {6{8'hA5}}, 8'h11, 8'h11},                                    1'b0};
      vecs[5] = '{1'b0, 6'd0,  8'h00, 9'h1FF, 6'd0,  6'd1,  9'h1FF, {8'h00, 8'h00, 8'h00, 8'h11, 8'h00, 8'hA5, 8'h00, 8'h00, 8'hC3},   1'b0};
      vecs[6] = '{1'b0, 6'd0,  8'h00, 9'h1FF, 6'd20, 6'd0,  9'h1FF, {9{8'h5A}},                                                           1'b0};
      vecs[7] = '{1'b1, 6'd12, 8'h77, 9'h0AA, 6'd12, 6'd1,  9'h0AA, {8'h5A, 8'h00, 8'h5A, 8'h00, 8'h5A, 8'h00, 8'h5A, 8'h00, 8'h5A},   1'b0};
      vecs[8] = '{1'b0, 6'd0,  8'h00, 9'h155, 6'd4,  6'd2,  9'h155, {8'h5A, 8'h00, 8'h00, 8'h00, 8'h77, 8'h00, 8'h00, 8'h00, 8'h00},   1'b0};

      // Reset values while reset is held.
      #2;
      check("rst_busy", o_busy, 1);
      check("rst_valid", o_valid, 0);
      check("rst_data", o_data, 0);
      check("rst_oob", o_oob, 0);
      cycle();
      cycle();
      rst_n = 1'b1;

      // Sweep after reset lasts exactly DEPTH cycles.
      n = 0;
      while (o_busy && n < 100) begin
         cycle();
         n++;
      end
      check("rst_busy_cycles", n, 21);
      read_all_zero("post_rst");

      // Table-driven single-cycle transactions.
      for (int i = 0; i < 9; i++) begin
         wr_en  = vecs[i].wr_en;
         w_addr = vecs[i].w_addr;
         w_data = vecs[i].w_data;
         set_reads(vecs[i].rd_en, vecs[i].r_base, vecs[i].r_step);
         cycle();
         quiet();
         check($sformatf("vec%0d_valid", i), o_valid, vecs[i].exp_valid);
         check($sformatf("vec%0d_data", i), o_data, vecs[i].exp_data);
         check($sformatf("vec%0d_oob", i), o_oob, vecs[i].exp_oob);
      end

      // Collision: write 0x3C to addr 5 (holding 0x11) while port 0 reads it.
      wr_en = 1'b1; w_addr = 6'd5; w_data = 8'h3C;
      set_reads(9'h001, 6'd5, 6'd0);
      cycle();
      quiet();
      check("coll_valid", o_valid, 9'h001);
`ifdef MULTIPORT_BRAM_BYPASS_EN
      check("coll_data", o_data[7:0], 8'h3C);
`else
      check("coll_data", o_data[7:0], 8'h11);
`endif
      set_reads(9'h002, 6'd5, 6'd0);
      cycle();
      quiet();
      check("coll_after", o_data[15:8], 8'h3C);

      // Out-of-range read and write.
      set_reads(9'h001, 6'd25, 6'd0);
      cycle();
      quiet();
      check("oob_rd_data", o_data[7:0], 8'h00);
      check("oob_rd_valid", o_valid, 9'h001);
      check("oob_rd_flag", o_oob, 1);
      wr_en = 1'b1; w_addr = 6'd30; w_data = 8'hEE;
      cycle();
      quiet();
      check("oob_wr_flag", o_oob, 1);
      set_reads(9'h003, 6'd30, 6'd48);
      cycle();
      quiet();
      check("oob_wr_unchanged", o_data[15:0], 16'h0000);
      check("oob_wr_valid", o_valid, 9'h003);

      // Fill with 0xFF, confirm, then clear.
      for (int a = 0; a < DEPTH; a++) begin
         wr_en = 1'b1; w_addr = 6'(a); w_data = 8'hFF;
         cycle();
      end
      quiet();
      set_reads(9'h1FF, 6'd0, 6'd1);
      cycle();
      quiet();
      check("fill_lo", o_data, {9{8'hFF}});
      set_reads(9'h1FF, 6'd12, 6'd1);
      cycle();
      quiet();
      check("fill_hi", o_data, {9{8'hFF}});

      clr = 1'b1;
      cycle();
      clr = 1'b0;
      check("clr_busy", o_busy, 1);
      check("clr_oob", o_oob, 0);
      n = 0;
      while (o_busy && n < 100) begin
         n++;
         wr_en = 1'b1; w_addr = 6'd2; w_data = 8'h99;
         set_reads(9'h1FF, 6'd0, 6'd1);
         clr = (n == 5);
         cycle();
         quiet();
         check($sformatf("clr_rd_valid%0d", n), o_valid, 0);
      end
      check("clr_busy_cycles", n, 21);
      read_all_zero("post_clr");
      check("post_clr_oob", o_oob, 0);

      // Latency-2 instance: strobe arrives one cycle later than latency-1.
      wr_en = 1'b1; w_addr = 6'd3; w_data = 8'hA5;
      cycle();
      quiet();
      set_reads(9'h004, 6'd3, 6'd0);
      cycle();
      quiet();
      check("lat1_valid", o_valid, 9'h004);
      check("lat2_early", o_valid2, 9'h000);
      cycle();
      check("lat2_valid", o_valid2, 9'h004);
      check("lat2_data", o_data2[23:16], 8'hA5);

      // Reset one cycle after a read: latency-2 result must never appear.
      set_reads(9'h001, 6'd3, 6'd0);
      cycle();
      quiet();
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid2", o_valid2, 0);
      check("mid_rst_data2", o_data2, 0);
      check("mid_rst_busy2", o_busy2, 1);
      check("mid_rst_valid1", o_valid, 0);
      cycle();
      cycle();
      rst_n = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 30; c++) begin
         cycle();
         if (o_valid2 != '0) seen = 1'b1;
      end
      check("mid_rst_no_valid", seen, 0);
      check("mid_rst_sweep_done", o_busy2, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/multiport_bram.md
MULTIPORT_BRAM -- requirements
Module: multiport_bram

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 6: address bits per port.
REQ-002 SHALL have parameter RAM_WIDTH, default 8: data word bits.
REQ-003 SHALL have parameter RAM_DEPTH, default 21: number of words, at most 2**ADDR_WIDTH.
REQ-004 SHALL have parameter RAM_PORTS, default 9: number of independent read ports.
REQ-005 SHALL have parameter READ_LATENCY, default 1: read latency of 1 or 2 cycles; any other value is an elaboration error.
REQ-006 SHALL have port i_clk, input, 1: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port i_rst_n, input, 1: reset, asynchronous, active-low.
REQ-008 SHALL have port i_clr, input, 1: pulse that requests a memory zeroing sweep.
REQ-009 SHALL have port i_wr_en, input, 1: write enable.
REQ-010 SHALL have port i_w_addrs, input, ADDR_WIDTH: write address.
REQ-011 SHALL have port i_data, input, RAM_WIDTH: write data.
REQ-012 SHALL have port i_rd_en, input, RAM_PORTS: per-port read enable.
REQ-013 SHALL have port i_r_addrs, input, ADDR_WIDTH*RAM_PORTS: packed read addresses; port k occupies bits [ADDR_WIDTH*k +: ADDR_WIDTH].
REQ-014 SHALL have port o_data, output, RAM_WIDTH*RAM_PORTS: packed read data in the same port order.
REQ-015 SHALL have port o_valid, output, RAM_PORTS: per-port read-data-valid strobe.
REQ-016 SHALL have port o_busy, output, 1: high while a clear sweep runs.
REQ-017 SHALL have port o_oob, output, 1: sticky out-of-range access flag.

Function
REQ-018 SHALL implement a state machine with states CLEAR and IDLE.
REQ-019 SHALL leave reset in CLEAR with sweep counter at 0.
REQ-020 SHALL, in CLEAR, write 0 to address counter each cycle and increment the counter; after address RAM_DEPTH-1 it SHALL go to IDLE, so a sweep lasts exactly RAM_DEPTH cycles.
REQ-021 SHALL go from IDLE to CLEAR on i_clr=1, restarting the counter at 0; i_clr SHALL be ignored while in CLEAR.
REQ-022 SHALL drive o_busy=1 exactly while in CLEAR.
REQ-023 SHALL, while o_busy=1, drop user writes and reads; o_valid SHALL stay 0 for any read issued during CLEAR.
REQ-024 SHALL, in IDLE with i_wr_en=1 and i_w_addrs<RAM_DEPTH, store i_data at i_w_addrs on the clock edge.
REQ-025 SHALL, for each port k with i_rd_en[k]=1 in IDLE, present the word on o_data lane k and pulse o_valid[k] for one cycle, READ_LATENCY cycles after the request.
REQ-026 SHALL hold o_data lane k at its last value while port k has no new valid read.
REQ-027 SHALL let all ports read any address, including the same one, in the same cycle without conflict.
REQ-028 SHALL make a read with address >= RAM_DEPTH return 0 with o_valid asserted, and SHALL ignore a write with address >= RAM_DEPTH.
REQ-029 SHALL set o_oob to 1 on any out-of-range read or write; only reset or the start of a clear sweep SHALL clear it.
REQ-030 SHALL give a read and a write to the same address in the same cycle the collision behaviour set under Configuration.

Reset
REQ-031 SHALL, on i_rst_n=0, immediately force o_data=0, o_valid=0, o_oob=0, o_busy=1, the state to CLEAR and the counter to 0.
REQ-032 SHALL flush in-flight reads when reset asserts mid-operation; no o_valid SHALL appear after reset releases until a new read is issued in IDLE.
REQ-033 SHALL NOT reset memory contents asynchronously; contents are zeroed only by the CLEAR sweep that follows reset.

Configuration
REQ-034 SHALL, with macro MULTIPORT_BRAM_BYPASS_EN defined, return the new i_data on a same-cycle read/write collision (write-first forwarding).
REQ-035 SHALL, without MULTIPORT_BRAM_BYPASS_EN, return the old stored word on a collision (read-first).

Structure
REQ-036 SHALL place the state enum (CLEAR, IDLE) and the allowed READ_LATENCY constants in package multiport_bram_pkg.
REQ-037 SHALL instantiate one sub-module, bram_read_port, per read port; it holds that port's address/enable pipeline, out-of-range zeroing, collision mux and valid strobe.

Verification
REQ-038 SHALL cover reset: release i_rst_n -> o_busy high for exactly 21 cycles, then a read of every address returns 0x00.
REQ-039 SHALL cover write then read: write 0xA5 to address 3; next cycle all 9 ports read address 3 -> all lanes show 0xA5 with o_valid=9'h1FF, READ_LATENCY cycles later.
REQ-040 SHALL cover a collision: write 0x3C to address 5 (old value 0x11) while port 0 reads address 5 -> 0x3C with MULTIPORT_BRAM_BYPASS_EN, 0x11 without it.
REQ-041 SHALL cover out-of-range: read address 25 -> data 0x00, o_valid=1, o_oob=1; write address 30 -> memory unchanged; i_clr -> o_oob returns to 0.
REQ-042 SHALL cover reset mid-read: assert i_rst_n=0 one cycle after a read with READ_LATENCY=2 -> o_valid never pulses for it, o_data=0.
REQ-043 SHALL cover a clear request: fill memory with 0xFF, pulse i_clr, issue reads during o_busy -> no o_valid; after 21 cycles all addresses read 0x00.
